instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Sequential instruction encoder/loader for the MIPS-lite single-cycle core; it is the writer-side counterpart of the opcode decoder.
- Accepts symbolic instruction descriptors over a valid/ready stream and packs them into 32-bit machine words.
- Uses exactly the opcodes the control unit decodes.
- Writes the words to instruction memory at consecutive word addresses over a write/ack handshake, then reports completion, word count and errors.

Parameters:
- AW, 8, instruction-memory word-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a program load at base_addr; ignored while busy=1.
- base_addr  in  AW  first word address; sampled when start is accepted.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  encoder can accept a descriptor.
- in_kind  in  3  0=R-format, 1=lw, 2=sw, 3=beq, 4=nori, 5=jal, 6=jsp, 7=illegal.
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field; R-format only.
- in_funct  in  6  funct field; R-format only.
- in_imm  in  26  I-format immediate = in_imm[15:0]; J-format target = in_imm[25:0].
- in_last  in  1  descriptor is the final one of the program.
- imem_we  out  1  write request; held until acknowledged.
- imem_addr  out  AW  write word address.
- imem_wdata  out  32  encoded instruction word.
- imem_ack  in  1  memory accepted the write this cycle.
- busy  out  1  load in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error; cleared when start is accepted.
- count  out  AW+1  words written since the last accepted start.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; address and data registers cleared.
- Reset during a load abandons the load. Any pending imem_we drops immediately; there is no partial completion and no done pulse.
- Opcodes:
  - R = 000000
  - lw = 100011
  - sw = 101011
  - beq = 000100
  - nori = 001101
  - jal = 000011
  - jsp = 010010
- Encoding:
  - R-format: {000000, rs, rt, rd, 00000, funct}.
  - lw/sw/beq/nori: {op, rs, rt, imm[15:0]}.
  - jal/jsp: {op, imm[25:0]}.
  - Fields that a format does not use are ignored.
- FSM states and transitions:
  - IDLE: in_ready=0, busy=0. On start: address <= base_addr, count <= 0, err <= 0, then go to LOAD.
  - LOAD: in_ready=1, busy=1. On in_valid, capture the encoded word and in_last (one-cycle encode latency).
    - Kind 7: set err, write nothing. If in_last, go to DONE; otherwise stay in LOAD.
    - Any other kind: go to WRITE.
  - WRITE: in_ready=0. imem_we=1 with imem_addr and imem_wdata held stable until imem_ack.
    - On ack: address+1, count+1.
    - Then go to DONE if the captured last flag is set, otherwise back to LOAD.
    - An ack in the same cycle imem_we rises is legal. Minimum 2 cycles per word.
  - DONE: done=1 for exactly one cycle, busy=1; then go to IDLE.
- Address wrap: an ack at address 2^AW-1 wraps the address to 0 and sets err. Writing continues.
- count saturates at 2^(AW+1)-1.
- imem_ack outside WRITE is ignored.
- in_valid outside LOAD is ignored; the descriptor is not consumed.
- start while busy (including DONE) is ignored; it does not clear err.
- count and err hold their values in IDLE until the next accepted start.

Test Plan:
- Encode sequence: start, base_addr=0x10; lw rs=2 rt=3 imm=0x0004; then R-format rs=1 rt=2 rd=3 funct=0x20 with in_last=1; ack in the same cycle each time.
  - Required writes: 0x10 <- 0x8C430004, then 0x11 <- 0x00221820.
  - done pulses once; count=2; err=0.
- Remaining opcodes:
  - sw rs=4 rt=5 imm=0xFFFC -> 0xAC85FFFC.
  - beq rs=1 rt=2 imm=3 -> 0x10220003.
  - nori rs=6 rt=7 imm=0x00FF -> 0x34C700FF.
  - jal imm=0x0000040 -> 0x0C000040.
  - jsp imm=0x0000100 -> 0x48000100.
- Memory backpressure: hold imem_ack=0 for 5 cycles.
  - imem_we, imem_addr and imem_wdata stay stable; in_ready=0.
  - On the ack cycle the address increments exactly once.
- Illegal descriptor: kind=7 in the middle of 3 descriptors.
  - Only 2 writes occur, at consecutive addresses; err=1.
  - err is cleared by the next start.
- Wrap (AW=8): base_addr=0xFF, two descriptors.
  - Writes go to 0xFF, then 0x00; err=1; count=2.
- Reset and start handling:
  - rst_n low during WRITE: imem_we drops immediately, all outputs read 0, and no done pulse follows.
  - start asserted during LOAD is ignored: base address and count are unchanged.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS-lite instruction descriptors into
// 32-bit machine words and writes them to instruction memory at consecutive
// word addresses, then reports completion, word count and errors.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           begin a load at base_addr (ignored while busy)
//   base_addr       first word address, sampled when start is accepted
//   in_valid/ready  descriptor stream handshake
//   in_kind         0=R 1=lw 2=sw 3=beq 4=nori 5=jal 6=jsp 7=illegal
//   in_rs/rt/rd     register fields
//   in_funct        R-format function field
//   in_imm          I-format imm = [15:0], J-format target = [25:0]
//   in_last         final descriptor of the program
//   imem_we/addr/wdata  memory write request, held until imem_ack
//   imem_ack        memory accepted the write this cycle
//   busy            load in progress
//   done            one-cycle completion pulse
//   err             sticky error (illegal kind or address wrap)
//   count           words written since the last accepted start (saturating)
module instr_encoder #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_kind,
   input  logic [4:0]    in_rs,
   input  logic [4:0]    in_rt,
   input  logic [4:0]    in_rd,
   input  logic [5:0]    in_funct,
   input  logic [25:0]   in_imm,
   input  logic          in_last,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   input  logic          imem_ack,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   count
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_NORI = 6'b001101;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_JSP  = 6'b010010;

   localparam logic [2:0] K_ILLEGAL = 3'd7;

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t      state;
   logic        last_q;
   logic [31:0] enc_word;

   // Combinational encode; the word is registered when the descriptor is taken.
   always_comb begin
      enc_word = '0;
      case (in_kind)
         3'd0:    enc_word = {OP_R, in_rs, in_rt, in_rd, 5'b00000, in_funct};
         3'd1:    enc_word = {OP_LW,   in_rs, in_rt, in_imm[15:0]};
         3'd2:    enc_word = {OP_SW,   in_rs, in_rt, in_imm[15:0]};
         3'd3:    enc_word = {OP_BEQ,  in_rs, in_rt, in_imm[15:0]};
         3'd4:    enc_word = {OP_NORI, in_rs, in_rt, in_imm[15:0]};
         3'd5:    enc_word = {OP_JAL,  in_imm};
         3'd6:    enc_word = {OP_JSP,  in_imm};
         default: enc_word = '0;
      endcase
   end

   // All handshake/status outputs are registered alongside the state so they
   // change only on clock edges (or immediately on reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_q     <= 1'b0;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         count      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  imem_addr <= base_addr;
                  count     <= '0;
                  err       <= 1'b0;
                  busy      <= 1'b1;
                  in_ready  <= 1'b1;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  if (in_kind == K_ILLEGAL) begin
                     // Dropped descriptor: flag it, write nothing.
                     err <= 1'b1;
                     if (in_last) begin
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                     end
                  end else begin
                     imem_wdata <= enc_word;
                     last_q     <= in_last;
                     in_ready   <= 1'b0;
                     imem_we    <= 1'b1;
                     state      <= WRITE;
                  end
               end
            end
            WRITE: begin
               if (imem_ack) begin
                  imem_we   <= 1'b0;
                  imem_addr <= imem_addr + 1'b1;
                  if (imem_addr == '1) err <= 1'b1;   // wrapped past top of memory
                  if (count != '1) count <= count + 1'b1;
                  if (last_q) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     in_ready <= 1'b1;
                     state    <= LOAD;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
module tb_instr_encoder;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_kind;
   logic [4:0]    in_rs, in_rt, in_rd;
   logic [5:0]    in_funct;
   logic [25:0]   in_imm;
   logic          in_last;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          imem_ack;
   logic          busy, done, err;
   logic [AW:0]   count;

   instr_encoder #(.AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
      .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ack(imem_ack),
      .busy(busy), .done(done), .err(err), .count(count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [AW-1:0] m_addr;
   int            m_cnt;
   bit            m_err;
   logic [AW-1:0] exp_a[$];
   logic [31:0]   exp_d[$];
   logic [AW-1:0] log_a[$];
   logic [31:0]   log_d[$];
   int            done_cnt;
   int            ack_mode;   // 0 random, 1 always ack, 2 never ack

   function automatic logic [31:0] model_enc(input int k, input logic [4:0] rs, rt, rd,
                                             input logic [5:0] fn, input logic [25:0] imm);
      logic [31:0] w;
      case (k)
         0: w = (rs << 21) | (rt << 16) | (rd << 11) | fn;
         1: w = (32'h23 << 26) | (rs << 21) | (rt << 16) | imm[15:0];
         2: w = (32'h2B << 26) | (rs << 21) | (rt << 16) | imm[15:0];
         3: w = (32'h04 << 26) | (rs << 21) | (rt << 16) | imm[15:0];
         4: w = (32'h0D << 26) | (rs << 21) | (rt << 16) | imm[15:0];
         5: w = (32'h03 << 26) | imm;
         default: w = (32'h12 << 26) | imm;
      endcase
      return w;
   endfunction

   // ---------------- memory ack driver ----------------
   always begin
      @(posedge clk);
      #1;
      case (ack_mode)
         0:       imem_ack = ($urandom_range(0, 2) == 0);
         1:       imem_ack = 1'b1;
         default: imem_ack = 1'b0;
      endcase
   end

   // ---------------- compare process ----------------
   bit            pend;
   logic [AW-1:0] pend_a;
   logic [31:0]   pend_d;
   bit            prev_done;

   always @(negedge clk) begin
      if (!rst_n) begin
         pend = 0;
         prev_done = 0;
      end else begin
         if (pend) begin
            chk("we_held", imem_we, 1'b1);
            chk("addr_held", imem_addr, pend_a);
            chk("data_held", imem_wdata, pend_d);
         end
         if (imem_we) chk("no_ready_in_write", in_ready, 1'b0);
         if (imem_we || in_ready) chk("busy_active", busy, 1'b1);
         if (done) begin
            done_cnt++;
            chk("done_single", prev_done, 1'b0);
         end
         prev_done = done;
         pend = imem_we && !imem_ack;
         pend_a = imem_addr;
         pend_d = imem_wdata;
         if (imem_we && imem_ack) begin
            log_a.push_back(imem_addr);
            log_d.push_back(imem_wdata);
            if (exp_a.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               chk("wr_addr", imem_addr, exp_a.pop_front());
               chk("wr_data", imem_wdata, exp_d.pop_front());
            end
         end
      end
   end

   // ---------------- stimulus tasks (entered/left at a negedge) ----------------
   task automatic do_start(input logic [AW-1:0] b);
      start = 1'b1;
      base_addr = b;
      @(negedge clk);
      start = 1'b0;
      m_addr = b;
      m_cnt = 0;
      m_err = 0;
      done_cnt = 0;
   endtask

   task automatic send_desc(input int k, input logic [4:0] rs, rt, rd,
                            input logic [5:0] fn, input logic [25:0] imm, input bit last);
      int n = 0;
      in_valid = 1'b1;
      in_kind = 3'(k);
      in_rs = rs; in_rt = rt; in_rd = rd;
      in_funct = fn; in_imm = imm; in_last = last;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         chk("desc_timeout", 0, 1);
      end else begin
         if (k == 7) begin
            m_err = 1;
         end else begin
            exp_a.push_back(m_addr);
            exp_d.push_back(model_enc(k, rs, rt, rd, fn, imm));
            if (m_addr == '1) m_err = 1;
            m_addr = m_addr + 1'b1;
            m_cnt++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic finish_prog(input string nm);
      int n = 0;
      while (done_cnt == 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk({nm, "_done_cnt"}, done_cnt, 1);
      chk({nm, "_count"}, count, m_cnt);
      chk({nm, "_err"}, err, m_err);
      chk({nm, "_pending"}, exp_a.size(), 0);
      chk({nm, "_idle"}, {busy, done, in_ready, imem_we}, 4'b0);
   endtask

   task automatic clear_logs();
      log_a.delete();
      log_d.delete();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0;
      start = 0; base_addr = 0; in_valid = 0; in_kind = 0;
      in_rs = 0; in_rt = 0; in_rd = 0; in_funct = 0; in_imm = 0; in_last = 0;
      imem_ack = 0; ack_mode = 1; done_cnt = 0;
      m_addr = 0; m_cnt = 0; m_err = 0;
      #3;
      chk("reset_outputs", {in_ready, imem_we, busy, done, err}, 5'b0);
      chk("reset_addr_cnt", {imem_addr, count}, 0);
      chk("reset_wdata", imem_wdata, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // encode sequence with same-cycle acks
      chk("model_pin_lw", model_enc(1, 2, 3, 0, 0, 26'h4), 32'h8C430004);
      clear_logs();
      do_start(8'h10);
      send_desc(1, 2, 3, 0, 0, 26'h0004, 0);
      send_desc(0, 1, 2, 3, 6'h20, 0, 1);
      finish_prog("encode");
      chk("enc_log_n", log_a.size(), 2);
      if (log_a.size() == 2) begin
         chk("enc_a0", log_a[0], 8'h10);
         chk("enc_d0", log_d[0], 32'h8C430004);
         chk("enc_a1", log_a[1], 8'h11);
         chk("enc_d1", log_d[1], 32'h00221820);
      end

      // remaining opcodes
      clear_logs();
      do_start(8'h50);
      send_desc(2, 4, 5, 0, 0, 26'h0FFFC, 0);
      send_desc(3, 1, 2, 0, 0, 26'h3, 0);
      send_desc(4, 6, 7, 0, 0, 26'h00FF, 0);
      send_desc(5, 0, 0, 0, 0, 26'h0000040, 0);
      send_desc(6, 0, 0, 0, 0, 26'h0000100, 1);
      finish_prog("opcodes");
      chk("ops_log_n", log_d.size(), 5);
      if (log_d.size() == 5) begin
         chk("op_sw",   log_d[0], 32'hAC85FFFC);
         chk("op_beq",  log_d[1], 32'h10220003);
         chk("op_nori", log_d[2], 32'h34C700FF);
         chk("op_jal",  log_d[3], 32'h0C000040);
         chk("op_jsp",  log_d[4], 32'h48000100);
      end

      // backpressure: ack held low 5 cycles
      do_start(8'h20);
      ack_mode = 2;
      send_desc(2, 4, 5, 0, 0, 26'h0FFFC, 1);
      repeat (5) begin
         chk("bp_state", {imem_we, in_ready}, 2'b10);
         chk("bp_addr", imem_addr, 8'h20);
         @(negedge clk);
      end
      ack_mode = 1;
      finish_prog("backpressure");
      chk("bp_addr_once", imem_addr, 8'h21);

      // illegal descriptor in the middle
      clear_logs();
      do_start(8'h60);
      send_desc(2, 1, 1, 0, 0, 26'h10, 0);
      send_desc(7, 3, 3, 3, 3, 26'h3, 0);
      send_desc(3, 2, 2, 0, 0, 26'h20, 1);
      finish_prog("illegal");
      chk("ill_err", err, 1'b1);
      chk("ill_log_n", log_a.size(), 2);
      if (log_a.size() == 2) begin
         chk("ill_a0", log_a[0], 8'h60);
         chk("ill_a1", log_a[1], 8'h61);
      end
      do_start(8'h70);
      chk("err_cleared", err, 1'b0);
      send_desc(4, 1, 2, 0, 0, 26'h5, 1);
      finish_prog("after_illegal");

      // address wrap
      clear_logs();
      do_start(8'hFF);
      send_desc(1, 1, 2, 0, 0, 26'h8, 0);
      send_desc(1, 3, 4, 0, 0, 26'hC, 1);
      finish_prog("wrap");
      chk("wrap_err", err, 1'b1);
      chk("wrap_count", count, 2);
      if (log_a.size() == 2) begin
         chk("wrap_a0", log_a[0], 8'hFF);
         chk("wrap_a1", log_a[1], 8'h00);
      end else chk("wrap_log_n", log_a.size(), 2);

      // start during LOAD is ignored
      clear_logs();
      do_start(8'h40);
      send_desc(0, 1, 1, 1, 6'h21, 0, 0);
      for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
      start = 1'b1;
      base_addr = 8'h80;
      @(negedge clk);
      start = 1'b0;
      send_desc(0, 2, 2, 2, 6'h22, 0, 1);
      finish_prog("start_in_load");
      if (log_a.size() == 2) chk("sil_a1", log_a[1], 8'h41);
      else chk("sil_log_n", log_a.size(), 2);

      // reset during WRITE
      do_start(8'h30);
      ack_mode = 2;
      send_desc(1, 1, 1, 0, 0, 26'h1, 0);
      chk("rst_pre_we", imem_we, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_outputs", {in_ready, imem_we, busy, done, err}, 5'b0);
      chk("rst_addr_cnt", {imem_addr, count}, 0);
      chk("rst_wdata", imem_wdata, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      exp_a.delete();
      exp_d.delete();
      done_cnt = 0;
      ack_mode = 0;
      repeat (10) @(negedge clk);
      chk("rst_no_done", done_cnt, 0);
      chk("rst_idle", {busy, imem_we}, 2'b0);

      // randomized programs
      for (int p = 0; p < 30; p++) begin
         int nd;
         do_start(8'($urandom_range(0, 255)));
         nd = $urandom_range(1, 6);
         for (int d = 0; d < nd; d++) begin
            send_desc($urandom_range(0, 7), 5'($urandom), 5'($urandom), 5'($urandom),
                      6'($urandom), 26'($urandom), d == nd - 1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
         end
         finish_prog("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
